// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, one bit per clock, start/done handshake.
// Optional SERIAL_ADDER_OVERFLOW_EN builds the two's-complement overflow capture; otherwise overflow is 0.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_r;
   logic [WIDTH-1:0] sa_r;
   logic [WIDTH-1:0] sb_r;
   logic [WIDTH-2:0] acc_r;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] result_r;
   logic             cout_r;

   logic             sum_s;
   logic             fa_cout_s;
   logic             last_s;
   logic [WIDTH-1:0] acc_next_s;

   // The single full-adder cell; sum bits enter at the MSB so the LSB ends up at bit 0.
   assign sum_s      = sa_r[0] ^ sb_r[0] ^ carry_r;
   assign fa_cout_s  = (sa_r[0] & sb_r[0]) | (carry_r & (sa_r[0] ^ sb_r[0]));
   assign last_s     = (cnt_r == LAST_BIT);
   assign acc_next_s = {sum_s, acc_r};

   // Sequencer, operand shift registers and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         sa_r     <= '0;
         sb_r     <= '0;
         acc_r    <= '0;
         carry_r  <= 1'b0;
         cnt_r    <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= '0;
         cout_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  sa_r    <= a;
                  sb_r    <= sub ? ~b : b;
                  carry_r <= sub ? 1'b1 : carry_in;
                  acc_r   <= '0;
                  cnt_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sa_r    <= sa_r >> 1;
               sb_r    <= sb_r >> 1;
               carry_r <= fa_cout_s;
               acc_r   <= acc_next_s[WIDTH-1:1];
               cnt_r   <= cnt_r + CW'(1);
               if (last_s) begin
                  result_r <= acc_next_s;
                  cout_r   <= fa_cout_s;
                  busy_r   <= 1'b0;
                  done_r   <= 1'b1;
                  state_r  <= ST_DONE;
               end else begin
                  state_r  <= ST_RUN;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SERIAL_ADDER_OVERFLOW_EN
   logic ovf_r;

   // Overflow = carry into the MSB (still in carry_r on the last bit) XOR carry out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if ((state_r == ST_RUN) && last_s) begin
         ovf_r <= carry_r ^ fa_cout_s;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign overflow = ovf_r;
`else
   assign overflow = 1'b0;
`endif

   assign busy      = busy_r;
   assign done      = done_r;
   assign result    = result_r;
   assign carry_out = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): stimulus pushes expected results, a monitor pops on done.
// Overflow expectations follow SERIAL_ADDER_OVERFLOW_EN.
module tb_serial_adder;

   localparam int W = 8;
`ifdef SERIAL_ADDER_OVERFLOW_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         carry_in = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   typedef struct {
      logic [W-1:0] res;
      logic         co;
      logic         ov;
      int           cyc;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
      .carry_in(carry_in), .busy(busy), .done(done), .result(result),
      .carry_out(carry_out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("result", {24'd0, result}, {24'd0, e.res});
            chk("carry_out", {31'd0, carry_out}, {31'd0, e.co});
            chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
            chk("latency", cyc, e.cyc);
         end
      end
   end

   // Drive start for one cycle (called at a negedge) and push the expected response.
   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                        input logic tsub, input logic [W-1:0] er, input logic eco, input logic eov);
      exp_t e;
      e.res = er; e.co = eco; e.ov = eov; e.cyc = cyc + 1 + W;
      sb_q.push_back(e);
      a = ta; b = tb; carry_in = tci; sub = tsub; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         if (done) return;
         @(negedge clk);
      end
      chk("done_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", {24'd0, result}, 32'd0);
      chk("rst_carry", {31'd0, carry_out}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      issue(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      chk("busy_run", {31'd0, busy}, 32'd1);
      wait_done(); @(negedge clk);
      issue(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      wait_done(); @(negedge clk);
      issue(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
      wait_done(); @(negedge clk);
      issue(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, OVF_EN);
      wait_done(); @(negedge clk);
      issue(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
      wait_done(); @(negedge clk);
      chk("idle_after_done", {31'd0, busy}, 32'd0);
      chk("result_held", {24'd0, result}, 32'h000000FE);

      // Start re-pulsed mid-RUN must be ignored.
      issue(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      a = 8'hAA; b = 8'h55; carry_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("result_stable_run", {24'd0, result}, 32'h000000FE);
      wait_done();
      // Back-to-back: start during the done cycle.
      issue(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, OVF_EN);
      chk("no_idle_gap", {31'd0, busy}, 32'd1);
      wait_done(); @(negedge clk);

      // Reset asserted mid-RUN aborts the operation.
      issue(8'h21, 8'h43, 1'b0, 1'b0, 8'h64, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_result", {24'd0, result}, 32'd0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 4) @(negedge clk);
      chk("no_done_after_abort", {31'd0, busy}, 32'd0);

      issue(8'h30, 8'h10, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0);
      wait_done(); @(negedge clk);
      chk("queue_drained", sb_q.size(), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
